dp_mem_responder: RTL

//  Synthesizable dual-port memory responder for the mp3 core's split I/D memory interface.

---
 rtl/dp_mem_responder_if.sv | 36 +++
 rtl/dp_mem_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dp_mem_responder_if.sv
// ---------------------------------------------------------------------------
// dp_mem_responder_if
//   One request/response memory port of the mp3 split I/D memory interface.
//   The initiator holds read or write, plus address/wdata/wmask, until it sees
//   the one-cycle resp pulse. rdata is meaningful only while resp is high.
//
//   Signals
//     read     initiator -> responder  read request, held until resp
//     write    initiator -> responder  write request, held until resp
//     wmask    initiator -> responder  byte enables (bit i -> wdata[8i+7:8i])
//     address  initiator -> responder  byte address
//     wdata    initiator -> responder  write data
//     resp     responder -> initiator  one-cycle completion pulse
//     rdata    responder -> initiator  read data, valid while resp=1
//
//   Modports: master (initiator side), slave (responder side).
// ---------------------------------------------------------------------------
interface dp_mem_responder_if;
    logic        read;
    logic        write;
    logic [3:0]  wmask;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        resp;
    logic [31:0] rdata;

    modport master (
        output read, write, wmask, address, wdata,
        input  resp, rdata
    );

    modport slave (
        input  read, write, wmask, address, wdata,
        output resp, rdata
    );
endinterface

// File: rtl/dp_mem_responder.sv
// ---------------------------------------------------------------------------
// dp_mem_responder
//   Dual-port word memory with real handshake timing. Port A backs instruction
//   fetch, port B data access. Each port runs an independent IDLE -> WAIT ->
//   RESP -> IDLE machine; a request is captured in IDLE, the access is
//   performed on the edge that enters RESP, and resp pulses for one cycle
//   LATENCY cycles after acceptance (resp follows edge k+LATENCY-1 when the
//   request is accepted at edge k).
//
//   Ports
//     clk           clock, all state on rising edge
//     rst_n         asynchronous active-low reset
//     port_a        slave port A (instruction side), LATENCY_A
//     port_b        slave port B (data side), LATENCY_B
//     protocol_err  sticky flag: an initiator broke the handshake on either
//                   port (read and write together in IDLE, or request
//                   fields / request level changed while waiting)
// ---------------------------------------------------------------------------
module dp_mem_responder #(
    parameter int ADDR_W    = 10,
    parameter int LATENCY_A = 1,
    parameter int LATENCY_B = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dp_mem_responder_if.slave    port_a,
    dp_mem_responder_if.slave    port_b,
    output logic                 protocol_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Index 0 is port A, index 1 is port B.
    logic [1:0]              rd_in;
    logic [1:0]              wr_in;
    logic [1:0][31:0]        addr_in;
    logic [1:0][31:0]        wdata_in;
    logic [1:0][3:0]         wmask_in;

    logic [1:0]              resp;
    logic [1:0][31:0]        rdata;
    logic [1:0]              we;        // write commits on this edge
    logic [1:0][ADDR_W-1:0]  widx;      // word touched on this edge
    logic [1:0][31:0]        cm_data;
    logic [1:0][3:0]         cm_mask;
    logic [1:0]              err_set;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    assign rd_in    = {port_b.read,    port_a.read};
    assign wr_in    = {port_b.write,   port_a.write};
    assign addr_in  = {port_b.address, port_a.address};
    assign wdata_in = {port_b.wdata,   port_a.wdata};
    assign wmask_in = {port_b.wmask,   port_a.wmask};

    assign port_a.resp  = resp[0];
    assign port_a.rdata = rdata[0];
    assign port_b.resp  = resp[1];
    assign port_b.rdata = rdata[1];

    for (genvar p = 0; p < 2; p++) begin : g_port
        localparam int         LAT      = (p == 0) ? LATENCY_A : LATENCY_B;
        localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

        state_t      state;
        state_t      state_next;
        logic [3:0]  cnt;          // edges left before entering RESP
        logic        op_write;
        logic [31:0] addr_q;
        logic [31:0] wdata_q;
        logic [3:0]  wmask_q;
        logic [31:0] rdata_q;
        logic        accept;
        logic        both_req;
        logic        enter_resp;
        logic        changed;
        logic        cm_write;

        always_comb begin
            // NOTE: every output of this block gets a default first so no
            // path through the case leaves a variable unassigned (no latch).
            state_next = state;
            accept     = 1'b0;
            both_req   = 1'b0;
            enter_resp = 1'b0;
            changed    = 1'b0;
            unique case (state)
                IDLE: begin
                    both_req = rd_in[p] & wr_in[p];
                    accept   = rd_in[p] ^ wr_in[p];
                    if (accept) begin
                        state_next = (LAT == 1) ? RESP : WAIT;
                        enter_resp = (LAT == 1);
                    end
                end
                WAIT: begin
                    // Anything moving under a captured request is an initiator
                    // error; the transaction still completes as captured.
                    changed = (rd_in[p] != !op_write) || (wr_in[p] != op_write) ||
                              (addr_in[p] != addr_q) || (wdata_in[p] != wdata_q) ||
                              (wmask_in[p] != wmask_q);
                    if (cnt == 4'd1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end
                end
                RESP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end

        // With LATENCY=1 the access happens on the accepting edge, so the
        // live inputs are used; otherwise the captured copy is used.
        assign cm_write   = (state == IDLE) ? wr_in[p]    : op_write;
        assign widx[p]    = (state == IDLE) ? addr_in[p][ADDR_W+1:2] : addr_q[ADDR_W+1:2];
        assign cm_data[p] = (state == IDLE) ? wdata_in[p] : wdata_q;
        assign cm_mask[p] = (state == IDLE) ? wmask_in[p] : wmask_q;
        // Gating with rst_n drops a write whose commit edge lands in reset.
        assign we[p]      = rst_n && enter_resp && cm_write;
        assign err_set[p] = both_req | changed;
        assign resp[p]    = (state == RESP);
        assign rdata[p]   = rdata_q;

        always_ff @(posedge clk or negedge rst_n) begin
            // NOTE: all sequential state uses non-blocking assignments so every
            // always_ff samples pre-edge values; this is also what gives the
            // read-before-write behaviour on same-edge collisions.
            if (!rst_n) begin
                state    <= IDLE;
                cnt      <= '0;
                op_write <= 1'b0;
                addr_q   <= '0;
                wdata_q  <= '0;
                wmask_q  <= '0;
                rdata_q  <= '0;
            end else begin
                state <= state_next;
                if (accept) begin
                    cnt      <= CNT_LOAD;
                    op_write <= wr_in[p];
                    addr_q   <= addr_in[p];
                    wdata_q  <= wdata_in[p];
                    wmask_q  <= wmask_in[p];
                end else if (state == WAIT) begin
                    cnt <= cnt - 4'd1;
                end
                if (enter_resp) begin
                    rdata_q <= cm_write ? 32'd0 : mem[widx[p]];
                end
            end
        end
    end

    // NOTE: the storage array has no reset; contents deliberately survive
    // rst_n and a reset loop over it would not map onto RAM.
    // Port B is written first and port A second, so where both ports enable
    // the same byte of the same word on one edge, port A's value lands.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[1] && cm_mask[1][i]) mem[widx[1]][8*i +: 8] <= cm_data[1][8*i +: 8];
            if (we[0] && cm_mask[0][i]) mem[widx[0]][8*i +: 8] <= cm_data[0][8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          protocol_err <= 1'b0;
        else if (|err_set)   protocol_err <= 1'b1;
    end

endmodule
